// File: rtl/pipe_id_recv.sv
// pipe_id_recv -- receive side of the IF->ID handshake.
//
// Buffers fetched {pc, inst} beats in a 2-entry FIFO and presents the head
// entry to the decoder through a second valid/ready pair. id_ready is derived
// only from registered occupancy, so decoder stalls never reach the fetch PC
// register combinationally.
//
// Optional feature: define PIPE_ID_RECV_BYPASS_EN to let a beat arriving at an
// empty buffer reach the decoder in the same cycle (zero latency). If the
// decoder takes it, the beat is never stored.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   flush_i      drop all buffered entries and the incoming beat
//   if_valid_i   fetch has a beat on ifToId_i
//   ifToId_i     fetched {pc, inst}
//   id_ready_o   buffer can accept a beat this cycle (state-only)
//   dec_valid_o  head entry valid for the decoder
//   dec_pc_o     head pc
//   dec_inst_o   head instruction
//   dec_ready_i  decoder consumes the head this cycle
//   occupancy_o  number of stored entries, 0..2

package pipe_id_recv_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifToId_t;
endpackage

module pipe_id_recv
  import pipe_id_recv_pkg::*;
#(
  parameter int          DEPTH  = 2,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        if_valid_i,
  input  ifToId_t     ifToId_i,
  output logic        id_ready_o,
  output logic        dec_valid_o,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_inst_o,
  input  logic        dec_ready_i,
  output logic [1:0]  occupancy_o
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  ifToId_t    entry_q [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;

  ifToId_t    head;
  logic       bypass_take;
  logic       push;
  logic       pop;

  assign id_ready_o  = (cnt != FULL);
  assign occupancy_o = cnt;

  // NOTE: every signal gets a default before any conditional override, so no
  // path through the block leaves a variable unassigned (no latch inferred).
  always_comb begin
    head        = entry_q[rp];
    dec_valid_o = (cnt != 2'd0) & ~flush_i;
    bypass_take = 1'b0;
`ifdef PIPE_ID_RECV_BYPASS_EN
    // Empty buffer: forward the incoming beat straight to the decoder.
    if (cnt == 2'd0) begin
      head        = ifToId_i;
      dec_valid_o = if_valid_i & ~flush_i;
      bypass_take = dec_valid_o & dec_ready_i;
    end
`endif
  end

  assign dec_pc_o   = head.pc;
  assign dec_inst_o = head.inst;

  // A bypassed beat is consumed without touching storage; pop only ever
  // applies to a stored entry.
  assign push = if_valid_i & id_ready_o & ~flush_i & ~bypass_take;
  assign pop  = dec_valid_o & dec_ready_i & ~flush_i & (cnt != 2'd0);

  // NOTE: the entry array is reset along with the control state because the
  // decoder-facing pc must read RST_PC straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      cnt <= 2'd0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '{pc: RST_PC, inst: 32'h0};
      end
    end else if (flush_i) begin
      // Entry data is deliberately left as-is; only the bookkeeping clears.
      cnt <= 2'd0;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      if (push) begin
        entry_q[wp] <= ifToId_i;
        wp          <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: doc/pipe_id_recv.md
# pipe_id_recv

Receive side of the IF→ID handshake. Accepts `ifToId_t` beats (pc, inst) when `if_valid_i` and `id_ready_o` are both high, and buffers them in a 2-entry FIFO. Presents the head entry to the decoder through a second valid/ready pair. Because `id_ready_o` depends only on registered state, the decoder's stall signal never reaches the PC register combinationally. Sits between the fetch stage and the decoder, and participates in pipeline flush.

## Interface
Parameters:
- DEPTH, 2, buffer entries; fixed at 2 (full throughput plus one skid slot).
- RST_PC, 32'h0, value of stored pc fields and `dec_pc_o` after reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  discard all buffered entries and the current incoming beat.
- if_valid_i  input  1  fetch stage has a valid beat on `ifToId_i`.
- ifToId_i  input  `ifToId_t` (64: pc 32, inst 32)  fetched pc and instruction.
- id_ready_o  output  1  buffer can accept a beat this cycle.
- dec_valid_o  output  1  head entry is valid for the decoder.
- dec_pc_o  output  32  head pc.
- dec_inst_o  output  32  head instruction.
- dec_ready_i  input  1  decoder consumes the head this cycle.
- occupancy_o  output  2  number of stored entries, 0..2.

## Operation
- State:
  - two entry registers {pc, inst}
  - 1-bit write pointer `wp` and 1-bit read pointer `rp`; both wrap 1→0
  - 2-bit `cnt`
- push = `if_valid_i & id_ready_o & ~flush_i`. On push, write `ifToId_i` into entry[`wp`] and advance `wp`.
- pop = `dec_valid_o & dec_ready_i & ~flush_i`. On pop, advance `rp`.
- `cnt` update: next `cnt` = `cnt` + push − pop. Push and pop in the same cycle leaves `cnt` unchanged, and both pointers advance.
- `id_ready_o` = (`cnt` != 2). It is purely registered-state-derived and has no path from `dec_ready_i`.
- `dec_valid_o` = (`cnt` != 0) & ~`flush_i`.
- `dec_pc_o` / `dec_inst_o` = entry[`rp`]. These hold the last-read entry when invalid; no zeroing.
- Flush has priority over everything:
  - next `cnt` = 0, `wp` = `rp` = 0.
  - Entry data is not cleared.
  - The incoming beat is dropped, even if `if_valid_i` is high.
- `occupancy_o` = `cnt`.
- Full (`cnt` = 2): `id_ready_o` = 0. A pop this cycle does not enable a same-cycle push; the next cycle shows `cnt` = 1 and ready = 1.
- Empty (`cnt` = 0): a pop is impossible because `dec_valid_o` = 0, except in bypass mode (see Configuration).
- Ordering is strict FIFO. No beat is duplicated or reordered across pointer wrap.

## Timing
- Reset, asynchronous, takes effect immediately; values persist until the first clock edge after deassertion:
  - `cnt` = 0, `wp` = `rp` = 0, entries = {RST_PC, 32'h0}.
  - `id_ready_o` = 1, `dec_valid_o` = 0, `dec_pc_o` = RST_PC, `dec_inst_o` = 0, `occupancy_o` = 0.
- Reset asserted mid-operation discards all entries with no drain.
- Latency, default build: a beat pushed at edge N appears on `dec_*` in the cycle after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while `dec_ready_i` = 1.
- With the decoder stalled, at most 2 beats are absorbed before `id_ready_o` falls.
- Flush at edge N:
  - `dec_valid_o` = 0 combinationally during the flush cycle.
  - After edge N, `id_ready_o` = 1 and the first post-flush beat may push in the next cycle.

## Configuration
- `PIPE_ID_RECV_BYPASS_EN` defined:
  - When `cnt` = 0, `dec_valid_o` = `if_valid_i & ~flush_i`, and `dec_pc_o` / `dec_inst_o` = `ifToId_i`, with zero latency.
  - If `dec_ready_i` = 1 in that cycle, the beat is consumed without being stored; `cnt` stays 0 and no pointer moves.
  - If `dec_ready_i` = 0, the beat is stored normally.
  - `id_ready_o` remains state-only.
- Not defined: no bypass; minimum latency is 1 cycle as described in Timing.

## Test plan
- Reset check: assert `rst_i` mid-stream with `cnt` = 2 → outputs immediately `id_ready_o` = 1, `dec_valid_o` = 0, `occupancy_o` = 0, `dec_pc_o` = RST_PC.
- Streaming: pcs 0x80000000, 0x80000004, 0x80000008 back-to-back with `dec_ready_i` = 1 → decoder sees the same pcs in order, one per cycle, with `occupancy_o` ≤ 1 and 1-cycle latency (0 latency with bypass).
- Backpressure: `dec_ready_i` = 0, offer 0x80000000 / 0x80000004 / 0x80000008 → first two accepted, `id_ready_o` = 0 while the third is held. Raise `dec_ready_i` → order 0x80000000, 0x80000004, 0x80000008 with no loss.
- Simultaneous push/pop at `cnt` = 1, held for 5 cycles → `occupancy_o` stays 1, pointers wrap, and the output order matches the input order.
- Flush with `cnt` = 2 and `if_valid_i` = 1 carrying pc 0x80000010 → `dec_valid_o` = 0 that cycle and `occupancy_o` = 0 next cycle. Then push a new beat with pc = 0x80001000 → it is the next output seen.
- Full-plus-pop: `cnt` = 2, `dec_ready_i` = 1, `if_valid_i` = 1 → no push that cycle (`id_ready_o` = 0), `occupancy_o` = 1 next cycle, and the push is accepted the following cycle.
